// File: rtl/alu_seq_ctrl.sv
// Nibble-serial ALU sequencer: one W-bit operation stepped 4 bits per cycle, LSB nibble first.
// Optional abort input is enabled by defining ALU_SEQ_ABORT_EN.
module alu_seq_ctrl #(
  parameter int NIB = 4
) (
  input  logic               hz100,
  input  logic               reset,
  input  logic               start,
`ifdef ALU_SEQ_ABORT_EN
  input  logic               abort,
`endif
  input  logic [2:0]         op,
  input  logic [4*NIB-1:0]   a,
  input  logic [4*NIB-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [4*NIB-1:0]   result,
  output logic               carry,
  output logic               ovf,
  output logic               zero,
  output logic [2:0]         nib_idx
);

  localparam int W = 4 * NIB;
  localparam logic [2:0] LAST_IDX = 3'(NIB - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [2:0]     op_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   partial_r;
  logic           chain_r;
  logic [2:0]     nib_idx_r;
  logic           busy_r;
  logic           done_r;
  logic [W-1:0]   result_r;
  logic           carry_r;
  logic           ovf_r;
  logic           zero_r;

  logic [4:0]     base_s;
  logic [3:0]     a_nib_s;
  logic [3:0]     b_nib_s;
  logic           fill_s;
  logic           last_s;
  logic [4:0]     nib_res_s;
  logic [W-1:0]   nib_mask_s;
  logic [W-1:0]   nib_ins_s;
  logic [W-1:0]   next_partial_s;
  logic [W-1:0]   b_eff_s;
  logic           carry_next_s;
  logic           ovf_next_s;
  logic           abort_s;

  // Returns {chain_out, nibble} for one 4-bit slice of the selected operation.
  function automatic logic [4:0] nib_op(input logic [2:0] f_op, input logic [3:0] ak,
                                        input logic [3:0] bk, input logic c, input logic fill);
    logic [4:0] res;
    case (f_op)
      OP_ADD:  res = {1'b0, ak} + {1'b0, bk} + {4'b0000, c};
      OP_SUB:  res = {1'b0, ak} + {1'b0, ~bk} + {4'b0000, c};
      OP_NOT:  res = {1'b0, ~ak};
      OP_AND:  res = {1'b0, ak & bk};
      OP_OR:   res = {1'b0, ak | bk};
      OP_XOR:  res = {1'b0, ak ^ bk};
      OP_SHL:  res = {ak, c};
      OP_SHR:  res = {1'b0, fill, ak[3:1]};
      default: res = 5'b00000;
    endcase
    return res;
  endfunction

`ifdef ALU_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Slice the current nibble, compute it, and merge it into the partial result.
  always_comb begin
    base_s         = {nib_idx_r, 2'b00};
    a_nib_s        = 4'(a_r >> base_s);
    b_nib_s        = 4'(b_r >> base_s);
    last_s         = (nib_idx_r == LAST_IDX);
    if (last_s) begin
      fill_s = 1'b0;
    end else begin
      fill_s = 1'(a_r >> ({1'b0, base_s} + 6'd4));
    end
    nib_res_s      = nib_op(op_r, a_nib_s, b_nib_s, chain_r, fill_s);
    nib_mask_s     = W'(4'hF) << base_s;
    nib_ins_s      = W'(nib_res_s[3:0]) << base_s;
    next_partial_s = (partial_r & ~nib_mask_s) | nib_ins_s;
    if (op_r == OP_SUB) begin
      b_eff_s = ~b_r;
    end else begin
      b_eff_s = b_r;
    end
    case (op_r)
      OP_ADD, OP_SUB: begin
        carry_next_s = nib_res_s[4];
        ovf_next_s   = (a_r[W-1] == b_eff_s[W-1]) && (next_partial_s[W-1] != a_r[W-1]);
      end
      OP_SHL: begin
        carry_next_s = a_r[W-1];
        ovf_next_s   = 1'b0;
      end
      OP_SHR: begin
        carry_next_s = a_r[0];
        ovf_next_s   = 1'b0;
      end
      default: begin
        carry_next_s = 1'b0;
        ovf_next_s   = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered status, result and flag outputs.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state_r   <= S_IDLE;
      op_r      <= 3'd0;
      a_r       <= '0;
      b_r       <= '0;
      partial_r <= '0;
      chain_r   <= 1'b0;
      nib_idx_r <= 3'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= '0;
      carry_r   <= 1'b0;
      ovf_r     <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_r      <= op;
            a_r       <= a;
            b_r       <= b;
            partial_r <= '0;
            chain_r   <= (op == OP_SUB);
            nib_idx_r <= 3'd0;
            busy_r    <= 1'b1;
            state_r   <= S_RUN;
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort_s) begin
            // Abandon the operation; previously reported result and flags stay intact.
            nib_idx_r <= 3'd0;
            busy_r    <= 1'b0;
            state_r   <= S_IDLE;
          end else begin
            partial_r <= next_partial_s;
            chain_r   <= nib_res_s[4];
            if (last_s) begin
              nib_idx_r <= 3'd0;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              result_r  <= next_partial_s;
              carry_r   <= carry_next_s;
              ovf_r     <= ovf_next_s;
              zero_r    <= (next_partial_s == '0);
              state_r   <= S_DONE;
            end else begin
              nib_idx_r <= nib_idx_r + 3'd1;
            end
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          nib_idx_r <= 3'd0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;
  assign carry   = carry_r;
  assign ovf     = ovf_r;
  assign zero    = zero_r;
  assign nib_idx = nib_idx_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: word-level reference model, decoupled negedge monitor.
module tb_alu_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic           hz100 = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [2:0]     op = 3'd0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done, carry, ovf, zero;
  logic [W-1:0]   result;
  logic [2:0]     nib_idx;

  alu_seq_ctrl #(.NIB(NIB)) dut (
    .hz100(hz100), .reset(reset), .start(start),
`ifdef ALU_SEQ_ABORT_EN
    .abort(abort),
`endif
    .op(op), .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .carry(carry), .ovf(ovf), .zero(zero), .nib_idx(nib_idx)
  );

  always #5 hz100 = ~hz100;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           next_ok = 0;
  int           errors = 0;
  int           checks = 0;
  logic         done_due = 1'b0;
  logic [W-1:0] held_res = '0;
  logic         held_c = 1'b0, held_v = 1'b0, held_z = 1'b0;

  // Whole-word reference: plain arithmetic on full operands.
  function automatic exp_t model(input logic [2:0] f_op, input logic [W-1:0] fa, input logic [W-1:0] fb, input int acc);
    exp_t e;
    logic [W:0] s;
    logic [W-1:0] bb;
    e.c = 1'b0; e.v = 1'b0; e.acc = acc;
    bb = (f_op == 3'd1) ? ~fb : fb;
    case (f_op)
      3'd0, 3'd1: begin
        s = {1'b0, fa} + {1'b0, bb} + ((f_op == 3'd1) ? (W+1)'(1) : (W+1)'(0));
        e.res = s[W-1:0];
        e.c = s[W];
        e.v = (fa[W-1] == bb[W-1]) && (e.res[W-1] != fa[W-1]);
      end
      3'd2: e.res = ~fa;
      3'd3: e.res = fa & fb;
      3'd4: e.res = fa | fb;
      3'd5: e.res = fa ^ fb;
      3'd6: begin e.res = fa << 1; e.c = fa[W-1]; end
      default: begin e.res = fa >> 1; e.c = fa[0]; end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model advances on the same edge the DUT samples its inputs.
  always @(posedge hz100) begin
    int e;
    e = cyc + 1;
    cyc <= e;
    done_due <= 1'b0;
    if (reset) begin
      q.delete();
      held_res <= '0; held_c <= 1'b0; held_v <= 1'b0; held_z <= 1'b0;
      next_ok <= e + 1;
    end else begin
`ifdef ALU_SEQ_ABORT_EN
      if (abort && q.size() > 0 && e > q[0].acc && e <= q[0].acc + NIB) begin
        void'(q.pop_front());
        next_ok <= e + 1;
      end else
`endif
      if (q.size() > 0 && e == q[0].acc + NIB) begin
        held_res <= q[0].res; held_c <= q[0].c; held_v <= q[0].v; held_z <= q[0].z;
        done_due <= 1'b1;
        void'(q.pop_front());
      end else if (start && e >= next_ok && q.size() == 0) begin
        q.push_back(model(op, a, b, e));
        next_ok <= e + NIB + 2;
      end
    end
  end

  // Monitor: compares every observable output once per cycle, away from the active edge.
  always @(negedge hz100) begin
    if (cyc >= 1) begin
      logic run;
      run = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].acc + NIB);
      chk("busy", 32'(busy), 32'(run));
      chk("nib_idx", 32'(nib_idx), run ? 32'(cyc - q[0].acc) : 32'd0);
      chk("done", 32'(done), 32'(done_due));
      chk("result", 32'(result), 32'(held_res));
      chk("flags", {29'd0, carry, ovf, zero}, {29'd0, held_c, held_v, held_z});
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (cyc + 1 < next_ok && n < 100) begin
      @(posedge hz100); #1;
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    wait_idle();
    op = o; a = x; b = y; start = 1'b1;
    @(posedge hz100); #1;
    start = 1'b0;
  endtask

  task automatic wait_nib(input logic [2:0] k);
    int n = 0;
    @(negedge hz100);
    while (nib_idx != k && n < 20) begin
      @(negedge hz100);
      n++;
    end
    if (n >= 20) chk("wait_nib_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge hz100);
    #1 reset = 1'b0;

    run_op(3'd0, 16'h7FFF, 16'h0001);
    run_op(3'd1, 16'h0005, 16'h0005);
    run_op(3'd1, 16'h0000, 16'h0001);
    run_op(3'd6, 16'h8421, 16'h0000);
    run_op(3'd7, 16'h8421, 16'h0000);
    run_op(3'd5, 16'hF0F0, 16'hFF00);
    run_op(3'd2, 16'h1234, 16'h0000);

    // Starts during RUN and during DONE must be dropped.
    run_op(3'd0, 16'h0001, 16'h0001);
    repeat (2) @(posedge hz100);
    #1 op = 3'd5; a = 16'h1234; b = 16'h1111; start = 1'b1;
    @(posedge hz100); #1 start = 1'b0;
    @(posedge hz100); #1 start = 1'b1;
    @(posedge hz100); #1 start = 1'b0;

    // Reset in the middle of an operation.
    run_op(3'd0, 16'h1111, 16'h2222);
    wait_nib(3'd2);
    reset = 1'b1;
    @(posedge hz100); #1 reset = 1'b0;
    run_op(3'd0, 16'hFFFF, 16'h0001);

`ifdef ALU_SEQ_ABORT_EN
    run_op(3'd0, 16'h0001, 16'h0001);
    run_op(3'd0, 16'hFFFF, 16'h0001);
    wait_nib(3'd1);
    abort = 1'b1;
    @(posedge hz100); #1 abort = 1'b0;
    run_op(3'd0, 16'hFFFF, 16'h0001);
`endif

    // Random traffic, including ignored starts and rare resets.
    for (int i = 0; i < 600; i++) begin
      @(posedge hz100); #1;
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      reset = ($urandom_range(0, 149) == 0);
`ifdef ALU_SEQ_ABORT_EN
      abort = ($urandom_range(0, 9) == 0);
`endif
    end
    @(posedge hz100); #1;
    start = 1'b0; reset = 1'b0; abort = 1'b0;
    repeat (NIB + 4) @(posedge hz100);
    #1 chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
